morse_digit_scheduler: RTL and testbench

- Buffers up to DEPTH user-entered decimal digits and plays them one at a time through a single morse_code_encoder instance.
- Owns the encoder's start/digit inputs: issues a one-cycle start, tracks encoder busy, and inserts a fixed inter-digit gap.
- Sits between the button/switch debouncers and the encoder. Replaces the encoder's internal digit storage for number mode.

---
 rtl/morse_digit_scheduler.sv | 170 +++++++++++++++++
 tb/tb_morse_digit_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : morse_digit_scheduler
// Description : Digit FIFO feeding one morse encoder with start/ack/gap pacing.
//               Optional loop playback when MORSE_SCHED_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_digit_scheduler #(
    parameter int DEPTH       = 8,
    parameter int GAP_CYCLES  = 30_000_000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [3:0]                   push_digit,
    input  logic                         play,
    input  logic                         clear,
`ifdef MORSE_SCHED_REPEAT_EN
    input  logic                         rpt,
`endif
    input  logic                         enc_busy,
    output logic                         enc_start,
    output logic [3:0]                   enc_digit,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fill;
    logic [GW-1:0]   gap_cnt;
    logic [AW-1:0]   ack_cnt;

    logic            rpt_en;
    logic            pop;
    logic            wb;
    logic            push_acc;
    logic            push_rej;
    logic            ack_to;
    logic [3:0]      head;

`ifdef MORSE_SCHED_REPEAT_EN
    assign rpt_en = rpt;
`else
    assign rpt_en = 1'b0;
`endif

    assign full  = (fill == FULL_LVL);
    assign empty = (fill == '0);
    assign count = fill;
    assign busy  = (state != S_IDLE);
    assign head  = mem[rd_ptr];

    // The head leaves the queue at the end of the ISSUE cycle; in loop mode
    // it is recycled to the tail, which occupies the write port that cycle.
    always_comb begin
        pop      = (state == S_ISSUE) && !clear;
        wb       = pop && rpt_en;
        push_acc = push && !clear && (push_digit <= 4'd9) && (!full || pop) && !wb;
        push_rej = push && !clear && !push_acc;
        ack_to   = (state == S_WAIT_ACK) && !enc_busy && (ack_cnt <= AW'(1)) && !clear;
    end

    always_ff @(posedge clk) begin
        if (wb)
            mem[wr_ptr] <= head;
        else if (push_acc)
            mem[wr_ptr] <= push_digit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            gap_cnt   <= '0;
            ack_cnt   <= '0;
            enc_start <= 1'b0;
            enc_digit <= 4'd0;
            err       <= 1'b0;
        end else begin
            err       <= push_rej || ack_to;
            enc_start <= 1'b0;
            if (clear) begin
                state  <= S_IDLE;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push_acc || wb)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push_acc && !(pop && !wb))
                    fill <= fill + CW'(1);
                else if (!push_acc && pop && !wb)
                    fill <= fill - CW'(1);

                case (state)
                    S_IDLE: begin
                        if (play && !empty) begin
                            state     <= S_ISSUE;
                            enc_start <= 1'b1;
                            enc_digit <= head;
                        end
                    end
                    S_ISSUE: begin
                        ack_cnt <= ACK_LOAD;
                        state   <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (enc_busy) begin
                            state <= S_WAIT_DONE;
                        end else if (ack_to) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            ack_cnt <= ack_cnt - AW'(1);
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!enc_busy) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            if (!empty) begin
                                state     <= S_ISSUE;
                                enc_start <= 1'b1;
                                enc_digit <= head;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_digit_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_digit_scheduler
// Description : Directed + randomized bench with a timestamp/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_digit_scheduler;

    localparam int DEPTH   = 8;
    localparam int GAP     = 5;
    localparam int ACK     = 4;
    localparam int ENC_LEN = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [3:0] push_digit = 4'd0;
    logic       play = 1'b0;
    logic       clear = 1'b0;
    logic       rpt_s = 1'b0;
    logic       enc_busy = 1'b0;
    logic       enc_start;
    logic [3:0] enc_digit;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    morse_digit_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rst(rst), .push(push), .push_digit(push_digit), .play(play), .clear(clear),
`ifdef MORSE_SCHED_REPEAT_EN
        .rpt(rpt_s),
`endif
        .enc_busy(enc_busy), .enc_start(enc_start), .enc_digit(enc_digit),
        .full(full), .empty(empty), .count(count), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_log[$];
    int start_cyc[$];
    int fall_cyc[$];
    bit enc_mute = 1'b0;
    int drop_pct = 0;
    int arm = 0;
    int bleft = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Encoder stand-in: busy rises 1-2 cycles after a start and lasts ENC_LEN cycles.
    always @(posedge clk) begin
        #1;
        if (arm > 0) begin
            arm--;
            if (arm == 0) bleft = ENC_LEN;
        end
        enc_busy = (bleft > 0);
        if (bleft > 0) bleft--;
        if (enc_start === 1'b1 && !enc_mute && ($urandom_range(0, 99) >= drop_pct))
            arm = $urandom_range(1, 2);
    end

    // Reference model: digit queue plus cycle timestamps for the pending event.
    int mq[$];
    bit m_start, m_run, m_err, wait_fall;
    int m_digit, ack_from, start_due;
    bit l_rst, l_push, l_play, l_clear, l_rpt, l_busy, prev_busy;
    int l_dig;

    task model_reset();
        mq.delete();
        m_start = 0; m_run = 0; m_err = 0; m_digit = 0;
        ack_from = -1; wait_fall = 0; start_due = -1;
    endtask

    task model_step();
        bit was_issue, nonempty, rptw, acc;
        int c, h;
        c = cyc - 1;
        was_issue = m_start;
        nonempty = (mq.size() > 0);
        m_err = 0;
        m_start = 0;
        if (l_clear) begin
            mq.delete();
            m_run = 0; ack_from = -1; wait_fall = 0; start_due = -1;
        end else begin
            rptw = was_issue && l_rpt;
            acc = l_push && (l_dig <= 9) && (mq.size() < DEPTH || was_issue) && !rptw;
            if (l_push && !acc) m_err = 1;
            if (was_issue) begin
                h = mq.pop_front();
                if (rptw) mq.push_back(h);
                ack_from = c;
            end
            if (acc) mq.push_back(l_dig);
            if (was_issue) begin
            end else if (ack_from >= 0) begin
                if (l_busy) begin
                    ack_from = -1; wait_fall = 1;
                end else if (c - ack_from >= ACK - 1) begin
                    m_err = 1; ack_from = -1; start_due = c + 1 + GAP;
                end
            end else if (wait_fall) begin
                if (!l_busy) begin
                    wait_fall = 0; start_due = c + 1 + GAP;
                end
            end else if (start_due >= 0) begin
                if (cyc == start_due) begin
                    start_due = -1;
                    if (nonempty) begin
                        m_start = 1; m_digit = mq[0];
                    end else begin
                        m_run = 0;
                    end
                end
            end else if (!m_run && l_play && nonempty) begin
                m_run = 1; m_start = 1; m_digit = mq[0];
            end
        end
    endtask

    always @(posedge clk) begin
        l_rst = rst; l_push = push; l_dig = int'(push_digit); l_play = play;
        l_clear = clear; l_rpt = rpt_s; l_busy = enc_busy;
        if (!l_busy && prev_busy) fall_cyc.push_back(cyc);
        prev_busy = l_busy;
        cyc++;
        if (!l_rst) model_reset();
        else model_step();
        #1;
        chk("enc_start", 32'(enc_start), 32'(m_start));
        chk("enc_digit", 32'(enc_digit), 32'(m_digit));
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("busy", 32'(busy), 32'(m_run));
        chk("err", 32'(err), 32'(m_err));
        if (enc_start === 1'b1) begin
            start_log.push_back(int'(enc_digit));
            start_cyc.push_back(cyc);
        end
    end

    task tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_push(input int d);
        push = 1'b1; push_digit = 4'(d);
        tick();
        push = 1'b0;
    endtask

    task do_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    task do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task clear_logs();
        start_log.delete(); start_cyc.delete(); fall_cyc.delete();
    endtask

    task automatic wait_idle(input int budget, output int at);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
        at = cyc;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (enc_busy !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_ack", 32'(enc_busy), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t, s, n;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        run(3);

        chk("rst_enc_start", 32'(enc_start), 32'd0);
        chk("rst_enc_digit", 32'(enc_digit), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Three-digit run with gap timing
        clear_logs();
        do_push(1); do_push(2); do_push(3);
        do_play();
        chk("play_latency", 32'(enc_start), 32'd1);
        chk("first_digit", 32'(enc_digit), 32'd1);
        wait_idle(400, t);
        chk("seq_len", 32'(start_log.size()), 32'd3);
        if (start_log.size() >= 3 && fall_cyc.size() >= 3) begin
            chk("seq_d0", 32'(start_log[0]), 32'd1);
            chk("seq_d1", 32'(start_log[1]), 32'd2);
            chk("seq_d2", 32'(start_log[2]), 32'd3);
            chk("gap1", 32'(start_cyc[1] - fall_cyc[0]), 32'd6);
            chk("gap2", 32'(start_cyc[2] - fall_cyc[1]), 32'd6);
            chk("idle_after_gap", 32'(t - fall_cyc[2]), 32'd6);
        end
        chk("seq_empty", 32'(empty), 32'd1);
        run(30);

        // Full FIFO and out-of-range digits
        for (int i = 0; i < DEPTH; i++) do_push(i);
        chk("full_flag", 32'(full), 32'd1);
        do_push(4);
        chk("full_err", 32'(err), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        tick();
        chk("full_err_once", 32'(err), 32'd0);
        do_clear();
        do_push(1);
        do_push(12);
        chk("range_err", 32'(err), 32'd1);
        chk("range_count", 32'(count), 32'd1);
        do_clear();

        // Encoder never acknowledges
        clear_logs();
        enc_mute = 1'b1;
        do_push(7);
        do_play();
        s = cyc;
        chk("to_start", 32'(enc_start), 32'd1);
        run(3);
        chk("to_err_early", 32'(err), 32'd0);
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_count", 32'(count), 32'd0);
        wait_idle(50, t);
        chk("to_idle_time", 32'(t - s), 32'(ACK + GAP));
        enc_mute = 1'b0;
        run(5);

        // Clear (with simultaneous push) during first digit
        clear_logs();
        do_push(5); do_push(6);
        do_play();
        wait_ack(10);
        run(3);
        clear = 1'b1; push = 1'b1; push_digit = 4'd3;
        tick();
        clear = 1'b0; push = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        run(60);
        chk("clr_starts", 32'(start_log.size()), 32'd1);

        // Asynchronous reset in the middle of a digit
        do_push(2);
        do_play();
        wait_ack(10);
        run(3);
        rst = 1'b0;
        #1;
        chk("arst_enc_start", 32'(enc_start), 32'd0);
        chk("arst_enc_digit", 32'(enc_digit), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        run(40);

`ifdef MORSE_SCHED_REPEAT_EN
        clear_logs();
        rpt_s = 1'b1;
        do_push(4); do_push(9);
        do_play();
        n = 0;
        while (start_log.size() < 6 && n < 600) begin
            tick();
            n++;
        end
        chk("rpt_starts", 32'(start_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < start_log.size(); i++)
            chk("rpt_digit", 32'(start_log[i]), (i % 2 == 0) ? 32'd4 : 32'd9);
        chk("rpt_count", 32'(count), 32'd2);
        rpt_s = 1'b0;
        wait_idle(400, t);
        chk("rpt_drain_empty", 32'(empty), 32'd1);
        run(30);
`endif

        // Random traffic
        drop_pct = 5;
        for (int i = 0; i < 3000; i++) begin
            push = ($urandom_range(0, 99) < 15);
            push_digit = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            play = ($urandom_range(0, 99) < 5);
            clear = ($urandom_range(0, 299) == 0);
            tick();
        end
        push = 1'b0; play = 1'b0; clear = 1'b0;
        wait_idle(800, t);
        drop_pct = 0;
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
